// File: rtl/pvr_pkg.sv
// pvr_pkg: shared ISP pass types, depth modes, pass order
// and scheduler states for the tile pipeline.
package pvr_pkg;

   localparam logic [2:0] TYPE_OPQ     = 3'd0;
   localparam logic [2:0] TYPE_OPQ_MOD = 3'd1;
   localparam logic [2:0] TYPE_TRN     = 3'd2;
   localparam logic [2:0] TYPE_TRN_MOD = 3'd3;
   localparam logic [2:0] TYPE_PT      = 3'd4;

   localparam logic [2:0] DC_GEQUAL = 3'd6;

   localparam logic [2:0] NPASS = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR_ISSUE,
      S_CLR_WAIT,
      S_SEL,
      S_PASS_ISSUE,
      S_PASS_WAIT,
      S_FLUSH,
      S_DONE
   } state_t;

   // Hardware pass order: opaque, opaque mod, punch-through,
   // translucent, translucent mod.
   function automatic logic [2:0] pass_order(input logic [2:0] i);
      logic [2:0] t;
      case (i)
         3'd0:    t = TYPE_OPQ;
         3'd1:    t = TYPE_OPQ_MOD;
         3'd2:    t = TYPE_PT;
         3'd3:    t = TYPE_TRN;
         3'd4:    t = TYPE_TRN_MOD;
         default: t = TYPE_OPQ;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/z_tile_sched.sv
// z_tile_sched: per-tile Z clear, ISP pass and writeback
// scheduler for the 32x32 on-chip Z buffer.
module z_tile_sched
   import pvr_pkg::*;
#(
   parameter int unsigned       WDOG_W     = 20,
   parameter logic [WDOG_W-1:0] WDOG_LIMIT = 20'hFFFFF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tile_start,
   input  logic [4:0] pass_mask,
   input  logic       abort,
   output logic       tile_busy,
   output logic       tile_done,
   output logic       timeout_err,
   output logic       clear_z,
   input  logic       clear_done,
   output logic       pass_start,
   input  logic       pass_done,
   output logic [2:0] type_cnt,
   input  logic [2:0] poly_depth_comp,
   input  logic       poly_zwd,
   output logic [2:0] depth_comp,
   output logic       z_write_disable,
   output logic       flush_req,
   input  logic       flush_ack
);

   localparam logic [WDOG_W-1:0] WDOG_LAST =
      WDOG_LIMIT - WDOG_W'(1);

   state_t            state;
   logic [4:0]        mask_r;
   logic [2:0]        idx;
   logic [WDOG_W-1:0] wdog;
   logic              wd_hit;
   logic              aborting;
   logic [2:0]        sel_type;

   assign wd_hit   = (wdog == WDOG_LAST);
   assign aborting = abort && (state != S_IDLE);
   assign sel_type = pass_order(idx);

   // Tile sequencing FSM with registered handshake outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         mask_r      <= '0;
         idx         <= '0;
         wdog        <= '0;
         tile_busy   <= 1'b0;
         tile_done   <= 1'b0;
         timeout_err <= 1'b0;
         clear_z     <= 1'b0;
         pass_start  <= 1'b0;
         type_cnt    <= '0;
         flush_req   <= 1'b0;
      end else if (aborting) begin
         state      <= S_IDLE;
         idx        <= '0;
         wdog       <= '0;
         tile_busy  <= 1'b0;
         tile_done  <= 1'b0;
         clear_z    <= 1'b0;
         pass_start <= 1'b0;
         type_cnt   <= '0;
         flush_req  <= 1'b0;
      end else begin
         clear_z    <= 1'b0;
         pass_start <= 1'b0;
         tile_done  <= 1'b0;
         wdog       <= '0;
         unique case (state)
            S_IDLE: begin
               if (tile_start) begin
                  mask_r      <= pass_mask;
                  timeout_err <= 1'b0;
                  tile_busy   <= 1'b1;
                  clear_z     <= 1'b1;
                  state       <= S_CLR_ISSUE;
               end
            end
            S_CLR_ISSUE: begin
               state <= S_CLR_WAIT;
            end
            S_CLR_WAIT: begin
               if (clear_done) begin
                  idx   <= '0;
                  state <= S_SEL;
               end else if (wd_hit) begin
                  timeout_err <= 1'b1;
                  tile_busy   <= 1'b0;
                  tile_done   <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  wdog <= wdog + WDOG_W'(1);
               end
            end
            S_SEL: begin
               if (idx >= NPASS) begin
                  flush_req <= 1'b1;
                  state     <= S_FLUSH;
               end else if (mask_r[sel_type]) begin
                  type_cnt   <= sel_type;
                  pass_start <= 1'b1;
                  state      <= S_PASS_ISSUE;
               end else begin
                  idx <= idx + 3'd1;
               end
            end
            S_PASS_ISSUE: begin
               state <= S_PASS_WAIT;
            end
            S_PASS_WAIT: begin
               if (pass_done) begin
                  idx   <= idx + 3'd1;
                  state <= S_SEL;
               end else if (wd_hit) begin
                  timeout_err <= 1'b1;
                  tile_busy   <= 1'b0;
                  tile_done   <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  wdog <= wdog + WDOG_W'(1);
               end
            end
            S_FLUSH: begin
               if (flush_ack || wd_hit) begin
                  timeout_err <= timeout_err
                                 | (wd_hit & ~flush_ack);
                  flush_req   <= 1'b0;
                  tile_busy   <= 1'b0;
                  tile_done   <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  wdog <= wdog + WDOG_W'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Depth mode toward the Z buffer, one cycle behind poly inputs.
   always_ff @(posedge clock) begin
      if (reset || aborting) begin
         depth_comp      <= '0;
         z_write_disable <= 1'b0;
      end else if (state == S_PASS_WAIT) begin
         unique case (1'b1)
            (type_cnt == TYPE_PT): begin
               depth_comp      <= DC_GEQUAL;
               z_write_disable <= poly_zwd;
            end
            (type_cnt == TYPE_OPQ_MOD),
            (type_cnt == TYPE_TRN_MOD): begin
               depth_comp      <= poly_depth_comp;
               z_write_disable <= 1'b1;
            end
            default: begin
               depth_comp      <= poly_depth_comp;
               z_write_disable <= poly_zwd;
            end
         endcase
      end else begin
         depth_comp      <= '0;
         z_write_disable <= 1'b1;
      end
   end

endmodule

// File: tb/tb_z_tile_sched.sv
// tb_z_tile_sched: directed bench for the tile scheduler;
// u_dut runs default watchdog, u_wd a 100-cycle watchdog.
module tb_z_tile_sched;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset;
   logic       abort;
   logic [2:0] poly_depth_comp;
   logic       poly_zwd;

   logic       tile_start, clear_done, pass_done, flush_ack;
   logic [4:0] pass_mask;
   logic       tile_busy, tile_done, timeout_err, clear_z;
   logic       pass_start, z_write_disable, flush_req;
   logic [2:0] type_cnt, depth_comp;

   logic       w_tile_start, w_clear_done, w_pass_done, w_flush_ack;
   logic [4:0] w_pass_mask;
   logic       w_tile_busy, w_tile_done, w_timeout_err, w_clear_z;
   logic       w_pass_start, w_z_write_disable, w_flush_req;
   logic [2:0] w_type_cnt, w_depth_comp;

   z_tile_sched u_dut (
      .clock(clock), .reset(reset), .tile_start(tile_start),
      .pass_mask(pass_mask), .abort(abort),
      .tile_busy(tile_busy), .tile_done(tile_done),
      .timeout_err(timeout_err), .clear_z(clear_z),
      .clear_done(clear_done), .pass_start(pass_start),
      .pass_done(pass_done), .type_cnt(type_cnt),
      .poly_depth_comp(poly_depth_comp), .poly_zwd(poly_zwd),
      .depth_comp(depth_comp), .z_write_disable(z_write_disable),
      .flush_req(flush_req), .flush_ack(flush_ack)
   );

   z_tile_sched #(.WDOG_W(20), .WDOG_LIMIT(20'd100)) u_wd (
      .clock(clock), .reset(reset), .tile_start(w_tile_start),
      .pass_mask(w_pass_mask), .abort(abort),
      .tile_busy(w_tile_busy), .tile_done(w_tile_done),
      .timeout_err(w_timeout_err), .clear_z(w_clear_z),
      .clear_done(w_clear_done), .pass_start(w_pass_start),
      .pass_done(w_pass_done), .type_cnt(w_type_cnt),
      .poly_depth_comp(poly_depth_comp), .poly_zwd(poly_zwd),
      .depth_comp(w_depth_comp),
      .z_write_disable(w_z_write_disable),
      .flush_req(w_flush_req), .flush_ack(w_flush_ack)
   );

   int total = 0;
   int bad   = 0;
   int n_clr = 0, n_ps = 0, n_done = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // event counters for u_dut, sampled 1 after the edge
   always begin
      @(posedge clock);
      #1;
      if (!reset) begin
         if (clear_z)    n_clr++;
         if (pass_start) n_ps++;
         if (tile_done)  n_done++;
      end
   end

   task automatic wait_on(input int sel, input int budget,
                          output bit hit);
      hit = 1'b0;
      for (int i = 0; i < budget; i++) begin
         case (sel)
            0:       hit = clear_z;
            1:       hit = pass_start | flush_req;
            2:       hit = w_clear_z;
            3:       hit = w_pass_start;
            4:       hit = w_flush_req;
            default: hit = 1'b1;
         endcase
         if (hit) break;
         @(negedge clock);
      end
   endtask

   function automatic logic [2:0] exp_dc(input logic [2:0] t,
                                         input logic [2:0] pdc);
      return (t == 3'd4) ? 3'd6 : pdc;
   endfunction

   function automatic logic exp_zwd(input logic [2:0] t,
                                    input logic pz);
      return (t == 3'd1 || t == 3'd3) ? 1'b1 : pz;
   endfunction

   task automatic run_tile(input logic [4:0] m,
                           input int clr_lat,
                           input bit depth_chk,
                           input bit inject,
                           input bit start_in_done);
      int ord [5] = '{0, 1, 4, 2, 3};
      logic [2:0] exp_q [$];
      int c0, p0, d0, k;
      bit hit;
      for (int j = 0; j < 5; j++)
         if (m[ord[j]]) exp_q.push_back(3'(ord[j]));
      c0 = n_clr; p0 = n_ps; d0 = n_done;
      @(negedge clock);
      pass_mask = m; tile_start = 1'b1;
      @(negedge clock);
      tile_start = 1'b0; pass_mask = '0;
      wait_on(0, 5, hit);
      check("clr_issue", 32'(hit), 1);
      check("busy_on", 32'(tile_busy), 1);
      if (inject) begin
         clear_done = 1'b1; tile_start = 1'b1; pass_mask = 5'h1f;
         @(negedge clock);
         clear_done = 1'b0; tile_start = 1'b0; pass_mask = '0;
         repeat (20) @(negedge clock);
         check("inj_no_pass", 32'(n_ps - p0), 0);
         check("inj_no_flush", 32'(flush_req), 0);
         check("inj_busy", 32'(tile_busy), 1);
      end else begin
         repeat (clr_lat) @(negedge clock);
      end
      check("zwd_clrwait", 32'(z_write_disable), 1);
      check("dc_clrwait", 32'(depth_comp), 0);
      clear_done = 1'b1;
      @(negedge clock);
      clear_done = 1'b0;
      k = 0;
      forever begin
         wait_on(1, 50, hit);
         if (!hit) begin
            check("sched_stall", 0, 1);
            break;
         end
         if (flush_req) break;
         if (k >= exp_q.size()) begin
            check("extra_pass", 32'(k), 32'(exp_q.size()));
            break;
         end
         check("type_cnt", 32'(type_cnt), 32'(exp_q[k]));
         if (depth_chk) begin
            poly_depth_comp = 3'd3; poly_zwd = 1'b0;
            repeat (2) @(negedge clock);
            check("dc_a", 32'(depth_comp), 32'(exp_dc(exp_q[k], 3'd3)));
            check("zwd_a", 32'(z_write_disable),
                  32'(exp_zwd(exp_q[k], 1'b0)));
            poly_depth_comp = 3'd5; poly_zwd = 1'b1;
            @(negedge clock);
            check("dc_b", 32'(depth_comp), 32'(exp_dc(exp_q[k], 3'd5)));
            check("zwd_b", 32'(z_write_disable),
                  32'(exp_zwd(exp_q[k], 1'b1)));
            repeat (7) @(negedge clock);
         end else begin
            repeat (10) @(negedge clock);
         end
         pass_done = 1'b1;
         @(negedge clock);
         pass_done = 1'b0;
         k++;
      end
      check("pass_cnt", 32'(k), 32'(exp_q.size()));
      check("flush_req", 32'(flush_req), 1);
      repeat (5) @(negedge clock);
      check("flush_hold", 32'(flush_req), 1);
      flush_ack = 1'b1;
      @(negedge clock);
      flush_ack = 1'b0;
      check("tile_done", 32'(tile_done), 1);
      check("busy_off", 32'(tile_busy), 0);
      check("flush_drop", 32'(flush_req), 0);
      if (start_in_done) begin
         tile_start = 1'b1; pass_mask = 5'h01;
      end
      @(negedge clock);
      tile_start = 1'b0; pass_mask = '0;
      check("done_pulse", 32'(tile_done), 0);
      repeat (3) @(negedge clock);
      check("idle_busy", 32'(tile_busy), 0);
      check("n_clear", 32'(n_clr - c0), 1);
      check("n_pstart", 32'(n_ps - p0), 32'(exp_q.size()));
      check("n_done", 32'(n_done - d0), 1);
      check("no_tmo", 32'(timeout_err), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int d0, p0;
      bit hit;
      reset = 1'b1; abort = 1'b0;
      poly_depth_comp = '0; poly_zwd = 1'b0;
      tile_start = 1'b0; pass_mask = '0; clear_done = 1'b0;
      pass_done = 1'b0; flush_ack = 1'b0;
      w_tile_start = 1'b0; w_pass_mask = '0; w_clear_done = 1'b0;
      w_pass_done = 1'b0; w_flush_ack = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_outs", {20'd0, tile_busy, tile_done, timeout_err,
                         clear_z, pass_start, type_cnt, depth_comp,
                         z_write_disable, flush_req}, 0);
      reset = 1'b0;

      run_tile(5'b00001, 1024, 1'b0, 1'b0, 1'b0);
      run_tile(5'b11111, 4, 1'b1, 1'b0, 1'b0);
      run_tile(5'b00000, 4, 1'b0, 1'b0, 1'b0);
      run_tile(5'b10100, 2, 1'b1, 1'b1, 1'b1);

      // abort three cycles into PASS_WAIT, with a pass_done
      d0 = n_done;
      @(negedge clock);
      pass_mask = 5'b00001; tile_start = 1'b1;
      @(negedge clock);
      tile_start = 1'b0; pass_mask = '0;
      wait_on(0, 5, hit);
      repeat (3) @(negedge clock);
      clear_done = 1'b1;
      @(negedge clock);
      clear_done = 1'b0;
      wait_on(1, 20, hit);
      check("ab_pstart", 32'(pass_start), 1);
      repeat (3) @(negedge clock);
      abort = 1'b1; pass_done = 1'b1;
      @(negedge clock);
      abort = 1'b0; pass_done = 1'b0;
      check("ab_busy", 32'(tile_busy), 0);
      check("ab_outs", {24'd0, tile_done, type_cnt, depth_comp,
                        z_write_disable, flush_req}, 0);
      p0 = n_ps;
      repeat (5) @(negedge clock);
      pass_done = 1'b1;
      @(negedge clock);
      pass_done = 1'b0;
      repeat (5) @(negedge clock);
      check("ab_no_done", 32'(n_done - d0), 0);
      check("ab_no_pass", 32'(n_ps - p0), 0);
      check("ab_idle", 32'(tile_busy | flush_req), 0);
      run_tile(5'b01010, 3, 1'b1, 1'b0, 1'b0);

      // watchdog on a stuck pass, 100-cycle limit
      w_pass_mask = 5'b00001; w_tile_start = 1'b1;
      @(negedge clock);
      w_tile_start = 1'b0; w_pass_mask = '0;
      wait_on(2, 5, hit);
      check("wd_clr", 32'(hit), 1);
      repeat (3) @(negedge clock);
      w_clear_done = 1'b1;
      @(negedge clock);
      w_clear_done = 1'b0;
      wait_on(3, 20, hit);
      check("wd_pstart", 32'(hit), 1);
      repeat (100) @(negedge clock);
      check("wd_pre_tmo", 32'(w_timeout_err), 0);
      check("wd_pre_busy", 32'(w_tile_busy), 1);
      @(negedge clock);
      check("wd_tmo", 32'(w_timeout_err), 1);
      check("wd_done", 32'(w_tile_done), 1);
      check("wd_busy", 32'(w_tile_busy), 0);
      repeat (2) @(negedge clock);
      check("wd_sticky", 32'(w_timeout_err), 1);
      w_pass_mask = 5'b00000; w_tile_start = 1'b1;
      @(negedge clock);
      w_tile_start = 1'b0;
      check("wd_clr_err", 32'(w_timeout_err), 0);
      check("wd_clr2", 32'(w_clear_z), 1);
      repeat (2) @(negedge clock);
      w_clear_done = 1'b1;
      @(negedge clock);
      w_clear_done = 1'b0;
      wait_on(4, 20, hit);
      check("wd_flush", 32'(hit), 1);
      w_flush_ack = 1'b1;
      @(negedge clock);
      w_flush_ack = 1'b0;
      check("wd_done2", 32'(w_tile_done), 1);
      check("wd_no_tmo", 32'(w_timeout_err), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/z_tile_sched.md
Name: z_tile_sched

Overview:
- Per-tile pass scheduler for the 32x32 on-chip Z buffer (1024 entries).
- On each tile_start it:
  - requests a Z clear and waits for it to finish;
  - steps through the enabled ISP pass types in hardware order, handshaking each pass with the rasterizer/list reader;
  - drives type_cnt, depth_comp and z_write_disable toward the Z buffer;
  - requests the tile writeback.
- Sits between the region-array walker (upstream) and the Z buffer / rasterizer (downstream).

Parameters:
- WDOG_W, 20, width of the per-wait watchdog counter.
- WDOG_LIMIT, 20'hFFFFF, wait cycles before a stuck handshake is abandoned.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous reset, active high.
- tile_start  in  1  pulse; begin a tile. Ignored unless idle.
- pass_mask  in  5  bit n set = pass type n present (0 opaque, 1 opaque mod, 2 trans, 3 trans mod, 4 punch-through).
- abort  in  1  abandon the current tile.
- tile_busy  out  1  high from tile_start acceptance until tile_done.
- tile_done  out  1  one-cycle pulse at end of tile.
- timeout_err  out  1  sticky; cleared only by reset or the next accepted tile_start.
- clear_z  out  1  one-cycle clear request to the Z buffer.
- clear_done  in  1  pulse from the Z buffer when the clear completes.
- pass_start  out  1  one-cycle pulse; rasterize the list for type_cnt.
- pass_done  in  1  pulse from the rasterizer; list exhausted.
- type_cnt  out  3  current pass type.
- poly_depth_comp  in  3  depth mode of the current polygon.
- poly_zwd  in  1  z-write-disable bit of the current polygon.
- depth_comp  out  3  mode sent to the Z buffer.
- z_write_disable  out  1  to the Z buffer.
- flush_req  out  1  level; tile colour/Z writeback request.
- flush_ack  in  1  pulse; writeback finished.

Behaviour:
- Reset values: all outputs 0; state IDLE; watchdog 0; pass index 0.
- States: IDLE, CLR_ISSUE, CLR_WAIT, SEL, PASS_ISSUE, PASS_WAIT, FLUSH, DONE.
- IDLE:
  - tile_start latches pass_mask into mask_r, clears timeout_err, sets tile_busy, next state CLR_ISSUE.
- CLR_ISSUE:
  - clear_z = 1 for exactly this cycle; next state CLR_WAIT.
  - A clear_done seen in this cycle is ignored.
- CLR_WAIT:
  - on clear_done, go to SEL with pass index 0.
- SEL:
  - Fixed order table: 0, 1, 4, 2, 3.
  - Advance the index past entries whose mask_r bit is 0, one index per cycle.
  - First set bit found: type_cnt <= that type, then go to PASS_ISSUE.
  - Index past the end: go to FLUSH.
  - mask 0 therefore means clear, then flush, no passes.
- PASS_ISSUE:
  - pass_start = 1 for one cycle; next state PASS_WAIT.
- PASS_WAIT:
  - pass_done is sampled here only.
  - On pass_done: index+1, back to SEL.
  - type_cnt holds stable from the SEL exit cycle until the next SEL exit.
- FLUSH:
  - flush_req = 1 until the cycle after flush_ack is sampled, then go to DONE.
- DONE:
  - tile_done = 1 for one cycle; tile_busy falls in the same cycle; next state IDLE.
  - A tile_start in the DONE cycle is ignored.
- Depth control (registered, 1-cycle latency from poly_* inputs):
  - type 4: depth_comp = 3'd6 (GEQUAL forced); z_write_disable = poly_zwd.
  - types 1, 3: depth_comp = poly_depth_comp; z_write_disable = 1 (forced).
  - types 0, 2: depth_comp = poly_depth_comp; z_write_disable = poly_zwd.
  - Outside PASS_WAIT: z_write_disable = 1, depth_comp = 0.
- Watchdog:
  - Counts cycles in CLR_WAIT, PASS_WAIT and FLUSH; zeroed on every state change.
  - When the count reaches WDOG_LIMIT: set timeout_err, drop flush_req, go to DONE.
  - tile_done still pulses.
- abort (any state other than IDLE):
  - Next state is IDLE; all outputs return to reset values next cycle.
  - No tile_done; timeout_err is kept.
  - abort in IDLE has no effect.
- Simultaneous events:
  - reset overrides abort.
  - abort overrides any handshake input in the same cycle.
  - A handshake pulse arriving in a state that does not expect it is dropped.

Decomposition:
- Shared package (pvr_pkg):
  - pass type constants TYPE_OPQ=0, TYPE_OPQ_MOD=1, TYPE_TRN=2, TYPE_TRN_MOD=3, TYPE_PT=4;
  - depth mode constant DC_GEQUAL=3'd6;
  - the 5-entry pass-order table;
  - state enum.
- No sub-module required. The watchdog is a small counter inside the block.

Test Plan:
- Mask 5'b00001; clear_done 1024 cycles after clear_z; pass_done 10 cycles after pass_start; flush_ack 5 cycles after flush_req rises → sequence clear_z, pass_start (type_cnt=0), flush_req, tile_done; exactly one tile_done.
- Mask 5'b11111 → pass_start order with type_cnt = 0, 1, 4, 2, 3. During type 1 and 3 passes, z_write_disable = 1 even when poly_zwd = 0. During type 4, depth_comp = 6 when poly_depth_comp = 3.
- Mask 5'b00000 → clear_z, then flush_req with no pass_start; tile_done follows the flush_ack.
- Hold pass_done low with WDOG_LIMIT = 100 → timeout_err rises after 100 wait cycles, then tile_done. The next tile_start clears timeout_err.
- Assert abort 3 cycles into PASS_WAIT → next cycle IDLE, tile_busy = 0, no tile_done. A later pass_done is ignored and a new tile runs normally.
- Inject clear_done in the CLR_ISSUE cycle, and tile_start during busy → both ignored; the block still waits for the real clear_done.
